// File: rtl/doorlock_seq_if.sv
// doorlock_seq_if: keypad-side strobes and lock status outputs bundled between encoder and lock
interface doorlock_seq_if #(
    parameter int DIGIT_W = 4,
    parameter int MAX_TRIES = 3
);
    logic digit_valid;
    logic [DIGIT_W-1:0] digit_in;
    logic enter;
    logic clear;
    logic set_mode;
    logic door_open;
    logic [1:0] seg_out;
    logic prog_mode;
    logic [$clog2(MAX_TRIES+1)-1:0] tries_left;
    modport master(output digit_valid, digit_in, enter, clear, set_mode,
                   input door_open, seg_out, prog_mode, tries_left);
    modport slave(input digit_valid, digit_in, enter, clear, set_mode,
                  output door_open, seg_out, prog_mode, tries_left);
endinterface

// File: rtl/doorlock_seq.sv
// doorlock_seq: multi-digit keypad lock with programmable password, retry limit, timed open and lockout
module doorlock_seq #(
    parameter int DIGIT_W = 4,
    parameter int NUM_DIGITS = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] PASSWORD_INIT = 16'h1234,
    parameter int MAX_TRIES = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    doorlock_seq_if.slave bus
);
    localparam int BW = DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int LW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, SET, LOCKOUT} state_t;
    state_t state;
    logic [BW-1:0] buffer, password, shifted;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic [LW-1:0] tries;
    logic full;
    assign full = count == CW'(NUM_DIGITS);
    assign shifted = (buffer << DIGIT_W) | BW'(bus.digit_in);
    assign bus.tries_left = tries;
    // Status outputs decode the state held before each edge, so they trail the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            buffer <= '0;
            count <= '0;
            password <= PASSWORD_INIT;
            timer <= '0;
            tries <= LW'(MAX_TRIES);
            bus.door_open <= 1'b0;
            bus.seg_out <= 2'b10;
            bus.prog_mode <= 1'b0;
        end else begin
            bus.door_open <= state == OPEN;
            bus.prog_mode <= state == SET;
            bus.seg_out <= state == OPEN ? 2'b01 : state == LOCKOUT ? 2'b11 :
                           (state == ENTRY || state == SET) ? 2'b00 : 2'b10;
            case (state)
                IDLE, ENTRY, SET: begin
                    if (bus.clear) begin
                        state <= IDLE;
                        buffer <= '0;
                        count <= '0;
                    end else if (bus.enter) begin
                        if (state == SET) begin
                            if (full) password <= buffer;
                            state <= IDLE;
                            buffer <= '0;
                            count <= '0;
                        end else begin
                            state <= CHECK;
                        end
                    end else if (bus.digit_valid) begin
                        if (!full) begin
                            buffer <= shifted;
                            count <= count + 1'b1;
                        end
                        if (state == IDLE) state <= ENTRY;
                    end
                end
                CHECK: begin
                    buffer <= '0;
                    count <= '0;
                    if (full && buffer == password) begin
                        state <= OPEN;
                        timer <= TW'(OPEN_CYCLES - 1);
                        tries <= LW'(MAX_TRIES);
                    end else if (tries > LW'(1)) begin
                        state <= IDLE;
                        tries <= tries - 1'b1;
                    end else begin
                        state <= LOCKOUT;
                        timer <= TW'(LOCKOUT_CYCLES - 1);
                        tries <= '0;
                    end
                end
                OPEN: begin
                    if (bus.set_mode) state <= SET;
                    else if (timer == '0) state <= IDLE;
                    else timer <= timer - 1'b1;
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        tries <= LW'(MAX_TRIES);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
